// File: rtl/bkm_pkg.sv
// Shared encodings for the BKM control-variable step: modes, signed digit
// codes, control-word binary-point formats and the ONE position per format.
package bkm_pkg;

    localparam logic MODE_E = 1'b0;
    localparam logic MODE_L = 1'b1;

    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_NEG  = 2'b11;

    localparam logic [1:0] FMT_Q2   = 2'b00;
    localparam logic [1:0] FMT_Q3   = 2'b01;
    localparam logic [1:0] FMT_Q4   = 2'b10;
    localparam logic [1:0] FMT_Q2B  = 2'b11;

    // Bit position of ONE within a control word of width cw.
    function automatic int one_shift(input logic [1:0] fmt, input int cw);
        case (fmt)
            FMT_Q2:  return cw - 2;
            FMT_Q3:  return cw - 3;
            FMT_Q4:  return cw - 4;
            FMT_Q2B: return cw - 2;
            default: return cw - 2;
        endcase
    endfunction

endpackage

// File: rtl/bkm_digit_term.sv
// Computes sh(d*x): the digit-scaled control word arithmetic-shifted right by n,
// saturating to all sign bits once n reaches the control-word width.
module bkm_digit_term
    import bkm_pkg::*;
#(
    parameter int CW    = 16,
    parameter int LOG2W = 6,
    parameter int LOG2N = 6
) (
    input  logic [1:0]       d_i,
    input  logic [CW-1:0]    x_i,
    input  logic [LOG2N-1:0] n_i,
    output logic [CW-1:0]    term_o
);

    logic [CW-1:0]        prod;
    logic signed [CW-1:0] shr;
    logic                 sat;

    // Illegal digit code 10 falls into default and contributes nothing.
    always_comb begin
        prod = '0;
        case (d_i)
            DIG_POS:  prod = x_i;
            DIG_NEG:  prod = -x_i;
            DIG_ZERO: prod = '0;
            default:  prod = '0;
        endcase
    end

    // CW is 2^(LOG2W-2), so any set bit at or above that position means n >= CW.
    assign sat    = |n_i[LOG2N-1:LOG2W-2];
    assign shr    = $signed(prod) >>> n_i;
    assign term_o = sat ? {CW{prod[CW-1]}} : shr;

endmodule

// File: rtl/bkm_control_step.sv
// One registered BKM iteration step on the reduced-precision control pair
// (u, v): E-mode subtracts the table constants, L-mode applies the complex digit.
module bkm_control_step
    import bkm_pkg::*;
#(
    parameter int W     = 64,
    parameter int LOG2W = 6,
    parameter int LOG2N = 6
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               srst,
    input  logic               enable,
    input  logic               mode,
    input  logic [1:0]         format,
    input  logic [LOG2N-1:0]   n,
    input  logic [1:0]         d_u_n,
    input  logic [1:0]         d_v_n,
    input  logic [W/4-1:0]     u_n,
    input  logic [W/4-1:0]     v_n,
    input  logic [W/4-1:0]     lut_u_n,
    input  logic [W/4-1:0]     lut_v_n,
    output logic [W/4-1:0]     u_np1,
    output logic [W/4-1:0]     v_np1
);

    localparam int CW = W / 4;

    logic [CW-1:0] one_sel, du_one, dv_one;
    logic [CW-1:0] t_uu, t_vv, t_uv, t_vu;
    logic [CW-1:0] e_u, e_v, l_u, l_v, pre_u, pre_v;
    logic [CW-1:0] u_d, v_d, u_q, v_q;

    function automatic logic [CW-1:0] scale_one(input logic [1:0] d, input logic [CW-1:0] one);
        case (d)
            DIG_POS: return one;
            DIG_NEG: return -one;
            default: return '0;
        endcase
    endfunction

    assign one_sel = CW'(1) << one_shift(format, CW);
    assign du_one  = scale_one(d_u_n, one_sel);
    assign dv_one  = scale_one(d_v_n, one_sel);

    bkm_digit_term #(.CW(CW), .LOG2W(LOG2W), .LOG2N(LOG2N)) u_term_uu (
        .d_i(d_u_n), .x_i(u_n), .n_i(n), .term_o(t_uu));
    bkm_digit_term #(.CW(CW), .LOG2W(LOG2W), .LOG2N(LOG2N)) u_term_vv (
        .d_i(d_v_n), .x_i(v_n), .n_i(n), .term_o(t_vv));
    bkm_digit_term #(.CW(CW), .LOG2W(LOG2W), .LOG2N(LOG2N)) u_term_uv (
        .d_i(d_u_n), .x_i(v_n), .n_i(n), .term_o(t_uv));
    bkm_digit_term #(.CW(CW), .LOG2W(LOG2W), .LOG2N(LOG2N)) u_term_vu (
        .d_i(d_v_n), .x_i(u_n), .n_i(n), .term_o(t_vu));

    assign e_u = u_n - lut_u_n;
    assign e_v = v_n - lut_v_n;
    assign l_u = u_n + du_one + t_uu - t_vv;
    assign l_v = v_n + dv_one + t_uv + t_vu;

    assign pre_u = (mode == MODE_L) ? l_u : e_u;
    assign pre_v = (mode == MODE_L) ? l_v : e_v;

    // Doubling wraps modulo 2^CW; the dropped MSB is intentional.
    assign u_d = {pre_u[CW-2:0], 1'b0};
    assign v_d = {pre_v[CW-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (arst || srst) begin
            u_q <= '0;
            v_q <= '0;
        end else if (enable) begin
            u_q <= u_d;
            v_q <= v_d;
        end
    end

    assign u_np1 = u_q;
    assign v_np1 = v_q;

endmodule

// File: tb/tb_bkm_control_step.sv
// Self-checking bench for bkm_control_step: a reference model pushes expected
// (u, v) pairs at drive time; they are popped and compared after the edge.
module tb_bkm_control_step;

    logic        clk;
    logic        arst, srst, enable, mode;
    logic [1:0]  format;
    logic [5:0]  n;
    logic [1:0]  d_u_n, d_v_n;
    logic [15:0] u_n, v_n, lut_u_n, lut_v_n;
    logic [15:0] u_np1, v_np1;

    logic [31:0] exp_q[$];
    logic [15:0] held_u, held_v;
    int          vec_cnt;
    int          err_cnt;

    bkm_control_step #(.W(64), .LOG2W(6), .LOG2N(6)) dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable), .mode(mode),
        .format(format), .n(n), .d_u_n(d_u_n), .d_v_n(d_v_n),
        .u_n(u_n), .v_n(v_n), .lut_u_n(lut_u_n), .lut_v_n(lut_v_n),
        .u_np1(u_np1), .v_np1(v_np1)
    );

    // clock / reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Reference model
    function automatic int dig_val(input logic [1:0] d);
        if (d == 2'b01) return 1;
        if (d == 2'b11) return -1;
        return 0;
    endfunction

    function automatic logic [15:0] model_sh(input logic [1:0] d, input logic [15:0] x, input logic [5:0] nn);
        int          p;
        int          ps;
        int          r;
        logic [15:0] pw;
        p  = dig_val(d) * int'($signed(x));
        pw = p[15:0];
        ps = int'($signed(pw));
        if (nn >= 6'd16) return (ps < 0) ? 16'hFFFF : 16'h0000;
        r = ps >>> nn;
        return r[15:0];
    endfunction

    function automatic logic [31:0] model_step(input logic md, input logic [1:0] fmt, input logic [5:0] nn,
                                               input logic [1:0] du, input logic [1:0] dv,
                                               input logic [15:0] uu, input logic [15:0] vv,
                                               input logic [15:0] lu, input logic [15:0] lv);
        int          one;
        int          su;
        int          sv;
        logic [15:0] wu;
        logic [15:0] wv;
        one = (fmt == 2'b01) ? 'h2000 : (fmt == 2'b10) ? 'h1000 : 'h4000;
        if (md == 1'b0) begin
            su = int'(uu) - int'(lu);
            sv = int'(vv) - int'(lv);
        end else begin
            su = int'(uu) + dig_val(du) * one + int'(model_sh(du, uu, nn)) - int'(model_sh(dv, vv, nn));
            sv = int'(vv) + dig_val(dv) * one + int'(model_sh(du, vv, nn)) + int'(model_sh(dv, uu, nn));
        end
        su = su * 2;
        sv = sv * 2;
        wu = su[15:0];
        wv = sv[15:0];
        return {wu, wv};
    endfunction

    // driver: apply one cycle of stimulus, push expectation, then check after the edge
    task automatic drive(input string tag, input logic a, input logic s, input logic en,
                         input logic md, input logic [1:0] fmt, input logic [5:0] nn,
                         input logic [1:0] du, input logic [1:0] dv,
                         input logic [15:0] uu, input logic [15:0] vv,
                         input logic [15:0] lu, input logic [15:0] lv);
        logic [31:0] e;
        logic [31:0] got_e;
        @(negedge clk);
        arst = a; srst = s; enable = en; mode = md; format = fmt; n = nn;
        d_u_n = du; d_v_n = dv; u_n = uu; v_n = vv; lut_u_n = lu; lut_v_n = lv;
        if (a || s)   e = 32'h0;
        else if (!en) e = {held_u, held_v};
        else          e = model_step(md, fmt, nn, du, dv, uu, vv, lu, lv);
        exp_q.push_back(e);
        held_u = e[31:16];
        held_v = e[15:0];
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got_e = exp_q.pop_front();
            check_val({tag, "_u"}, u_np1, got_e[31:16]);
            check_val({tag, "_v"}, v_np1, got_e[15:0]);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        held_u  = 16'h0;
        held_v  = 16'h0;
        arst = 1'b0; srst = 1'b0; enable = 1'b0; mode = 1'b0; format = 2'b00; n = '0;
        d_u_n = '0; d_v_n = '0; u_n = '0; v_n = '0; lut_u_n = '0; lut_v_n = '0;

        // Reset behaviour
        drive("srst", 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 6'd3, 2'b01, 2'b11, 16'h1234, 16'h5678, 16'h1111, 16'h2222);
        check_val("srst_zero_u", u_np1, 16'h0000);
        drive("load", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0, 2'b00, 2'b00, 16'h0300, 16'h0500, 16'h0100, 16'h0100);
        drive("arst", 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 6'd1, 2'b11, 2'b01, 16'h7777, 16'h8888, 16'h0001, 16'h0002);
        check_val("arst_zero_v", v_np1, 16'h0000);
        drive("post_rst_hold", 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 6'd2, 2'b01, 2'b01, 16'h4321, 16'h1234, 16'h0F0F, 16'hF0F0);
        check_val("post_rst_hold_u", u_np1, 16'h0000);

        // E-mode, digits irrelevant
        for (int i = 0; i < 4; i++) begin
            drive("emode", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 6'($urandom_range(0, 63)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'h1000, 16'h0000, 16'h0800, 16'h0000);
            check_val("emode_const_u", u_np1, 16'h1000);
            check_val("emode_const_v", v_np1, 16'h0000);
        end

        // L-mode directed cases
        drive("l_real", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 6'd1, 2'b01, 2'b00, 16'hE000, 16'h0000, 16'h0, 16'h0);
        check_val("l_real_const_u", u_np1, 16'h2000);
        drive("l_imag", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 6'd2, 2'b00, 2'b01, 16'h0000, 16'hF000, 16'h0, 16'h0);
        check_val("l_imag_const_u", u_np1, 16'h0800);
        check_val("l_imag_const_v", v_np1, 16'h6000);
        drive("l_bign", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 6'd20, 2'b01, 2'b00, 16'hFFFF, 16'h0000, 16'h0, 16'h0);
        check_val("l_bign_const_u", u_np1, 16'h7FFC);
        check_val("l_bign_const_v", v_np1, 16'h0000);
        // sh(-0x2100) at n=20 floors to -1: 2*(0x2100 - 0x4000 - 1) wraps to 0xC1FE
        drive("l_wrap", 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 6'd20, 2'b11, 2'b00, 16'h2100, 16'h0000, 16'h0, 16'h0);
        check_val("l_wrap_const_u", u_np1, 16'hC1FE);

        // Hold with changed inputs, then format 01 and illegal digit
        drive("hold", 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 6'd5, 2'b11, 2'b11, 16'h1357, 16'h2468, 16'h0, 16'h0);
        check_val("hold_const_u", u_np1, 16'hC1FE);
        drive("fmt01", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 6'd63, 2'b01, 2'b00, 16'h0000, 16'h0000, 16'h0, 16'h0);
        check_val("fmt01_const_u", u_np1, 16'h4000);
        drive("illegal", 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 6'd63, 2'b10, 2'b00, 16'h0000, 16'h0000, 16'h0, 16'h0);
        check_val("illegal_const_u", u_np1, 16'h0000);
        drive("fmt10", 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 6'd4, 2'b11, 2'b01, 16'h0123, 16'h0456, 16'h0, 16'h0);

        // Randomized back-to-back stream with occasional holds and resets
        for (int i = 0; i < 60; i++) begin
            drive("rand", 1'b0, 1'b0 + ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
